// File: rtl/alu_op_pkg.sv
// ============================================================================
//  Module      : alu_op_pkg
//  Description : Operation codes, FSM states and helpers for the execute ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_op_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SRA   = 4'b0111,
        OP_BEQ   = 4'b1000,
        OP_BNE   = 4'b1001,
        OP_ILL_A = 4'b1010,
        OP_BGE   = 4'b1011,
        OP_SLT   = 4'b1100,
        OP_JAL   = 4'b1101,
        OP_BLT   = 4'b1110,
        OP_ILL_F = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb_core.sv
// ============================================================================
//  Module      : alu_comb_core
//  Description : Single-cycle ALU operations and illegal-opcode detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb_core
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    logic w_eq;
    logic w_lt;

    assign w_eq = (a == b);
    assign w_lt = ($signed(a) < $signed(b));

    // Shift codes are handled iteratively by the parent and yield 0 here.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:           result = a & b;
            OP_OR:            result = a | b;
            OP_ADD:           result = a + b;
            OP_XOR:           result = a ^ b;
            OP_SUB:           result = a - b;
            OP_BEQ:           result = DATA_WIDTH'(w_eq);
            OP_BNE:           result = DATA_WIDTH'(!w_eq);
            OP_BGE:           result = DATA_WIDTH'(!w_lt);
            OP_SLT:           result = DATA_WIDTH'(w_lt);
            OP_BLT:           result = DATA_WIDTH'(w_lt);
            OP_JAL:           result = a + DATA_WIDTH'(4);
            OP_ILL_A,
            OP_ILL_F:         illegal = 1'b1;
            default:          result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_exec.sv
// ============================================================================
//  Module      : alu_seq_exec
//  Description : Handshaked execute-stage ALU with bit-serial shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_exec
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  illegal_op
);

    state_e                  r_state;
    alu_op_e                 r_op;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_illegal;

    alu_op_e                 w_op;
    logic                    w_accept;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic [DATA_WIDTH-1:0]   w_core_result;
    logic                    w_core_illegal;
    logic [DATA_WIDTH-1:0]   w_acc_next;

    assign w_op     = alu_op_e'(Operation);
    assign w_shamt  = SrcB[SHAMT_WIDTH-1:0];
    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    assign out_valid  = (r_state == DONE);
    assign ALUResult  = r_result;
    assign illegal_op = r_illegal;
    assign Zero       = (r_result == '0);

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .op      (w_op),
        .a       (SrcA),
        .b       (SrcB),
        .result  (w_core_result),
        .illegal (w_core_illegal)
    );

    // One-bit step in the captured direction; SRA replicates the sign bit.
    always_comb begin
        w_acc_next = r_acc;
        case (r_op)
            OP_SLL:  w_acc_next = {r_acc[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  w_acc_next = {1'b0, r_acc[DATA_WIDTH-1:1]};
            OP_SRA:  w_acc_next = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= OP_AND;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        if (is_shift(w_op)) begin
                            r_acc     <= SrcA;
                            r_illegal <= 1'b0;
                            if (w_shamt == '0) begin
                                r_result <= SrcA;
                                r_state  <= DONE;
                            end else begin
                                r_cnt   <= w_shamt;
                                r_state <= SHIFT;
                            end
                        end else begin
                            r_result  <= w_core_result;
                            r_illegal <= w_core_illegal;
                            r_state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - SHAMT_WIDTH'(1);
                    if (r_cnt == SHAMT_WIDTH'(1)) begin
                        r_result <= w_acc_next;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// ============================================================================
//  Module      : tb_alu_seq_exec
//  Description : Directed self-checking bench for alu_seq_exec.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal_op;

    int n_checks;
    int n_pass;

    alu_seq_exec #(
        .DATA_WIDTH  (32),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Operation  (Operation),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for out_valid, check latency and outputs; with
    // out_ready high also check the return to IDLE after the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int cycles;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        Operation = 4'hA;
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'h1234_5678;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq({tag, "_latency"}, 32'(cycles + 1), 32'(exp_lat));
        check_eq({tag, "_result"}, ALUResult, exp_res);
        check_eq({tag, "_zero"}, 32'(Zero), 32'(exp_res == 32'd0));
        check_eq({tag, "_illegal"}, 32'(illegal_op), 32'(exp_ill));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_ready_back"}, {30'd0, in_ready, out_valid}, 32'b10);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'h0;
        SrcA      = '0;
        SrcB      = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", ALUResult, 32'd0);
        check_eq("rst_zero", 32'(Zero), 32'd1);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("add",  4'b0010, 32'h5,          32'h7,          32'hC,          1'b0, 1);
        run_op("sub",  4'b0110, 32'h3,          32'h5,          32'hFFFF_FFFE,  1'b0, 1);
        run_op("blt",  4'b1110, 32'hFFFF_FFFF,  32'h1,          32'h1,          1'b0, 1);
        run_op("bge",  4'b1011, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b0, 1);
        run_op("sra",  4'b0111, 32'h8000_0000,  32'h4,          32'hF800_0000,  1'b0, 5);
        run_op("sll0", 4'b0100, 32'h1,          32'h0,          32'h1,          1'b0, 1);
        run_op("srl31",4'b0101, 32'hFFFF_FFFF,  32'h1F,         32'h1,          1'b0, 32);
        run_op("and",  4'b0000, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 1);
        run_op("or",   4'b0001, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 1);
        run_op("beq",  4'b1000, 32'h7,          32'h7,          32'h1,          1'b0, 1);
        run_op("bne",  4'b1001, 32'h7,          32'h7,          32'h0,          1'b0, 1);
        run_op("slt",  4'b1100, 32'h8000_0000,  32'h0,          32'h1,          1'b0, 1);
        run_op("addwr",4'b0010, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b0, 1);
        run_op("sll3", 4'b0100, 32'h1,          32'h3,          32'h8,          1'b0, 4);
        run_op("ill_f",4'b1111, 32'h5,          32'h5,          32'h0,          1'b1, 1);
        run_op("ill_a",4'b1010, 32'h5,          32'h6,          32'h0,          1'b1, 1);
        run_op("jal",  4'b1101, 32'h100,        32'h0,          32'h104,        1'b0, 1);

        // Backpressure: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        run_op("xor",  4'b0011, 32'hF0F0,       32'h0FF0,       32'hFF00,       1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            Operation = 4'b0010;
            SrcA      = 32'h1;
            SrcB      = 32'h1;
            @(posedge clk);
            #1;
            check_eq("bp_hold", {ALUResult[15:0], 13'd0, out_valid, in_ready, illegal_op},
                     {16'hFF00, 13'd0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        #1;
        check_eq("bp_no_extra", 32'(out_valid), 32'd0);

        // Reset in the middle of a 10-bit SLL discards it.
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = 4'b0100;
        SrcA      = 32'h1;
        SrcB      = 32'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_result", ALUResult, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_ready_after", 32'(in_ready), 32'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen = 1'b1;
            end
            check_eq("mid_rst_no_stale", 32'(seen), 32'd0);
        end

        run_op("post_rst_add", 4'b0010, 32'h10, 32'h20, 32'h30, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
